// File: rtl/pwr_btn_pkg.sv
// rtl/pwr_btn_pkg.sv - shared state encodings and output decode for the power-button controller
package pwr_btn_pkg;

    localparam int TW_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_ON       = 3'd2,
        ST_SHDN_REQ = 3'd3,
        ST_PWR_DOWN = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    typedef struct packed {
        logic pwr_en;
        logic shdn_req;
        logic fault;
    } outs_t;

    // Unused codes decode to everything off so a corrupted state is safe.
    function automatic outs_t decode_outs(input state_e st);
        outs_t o;
        o = '0;
        case (st)
            ST_PWR_UP:   o.pwr_en = 1'b1;
            ST_ON:       o.pwr_en = 1'b1;
            ST_SHDN_REQ: begin
                o.pwr_en   = 1'b1;
                o.shdn_req = 1'b1;
            end
            ST_FAULT:    o.fault = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pwr_btn_press_cls.sv
// rtl/pwr_btn_press_cls.sv - classifies button presses into short and long events
module pwr_btn_press_cls
    import pwr_btn_pkg::*;
#(
    parameter int TW            = TW_DEFAULT,
    parameter int SHORT_MIN_MS  = 50,
    parameter int LONG_PRESS_MS = 4000
) (
    input  logic clock,
    input  logic reset,
    input  logic int_1ms_en,
    input  logic btn_n,
    output logic short_evt,
    output logic long_evt
);

    localparam logic [TW-1:0] SHORT_T   = TW'(SHORT_MIN_MS);
    localparam logic [TW-1:0] LONG_T    = TW'(LONG_PRESS_MS);
    localparam logic [TW-1:0] LONG_M1_T = TW'(LONG_PRESS_MS - 1);

    logic [TW-1:0] press_ms_q, press_ms_d;
    logic          btn_n_prev_q, btn_n_prev_d;

    always_comb begin
        press_ms_d   = press_ms_q;
        btn_n_prev_d = btn_n;
        if (btn_n) begin
            press_ms_d = '0;
        end else if (int_1ms_en && (press_ms_q < LONG_T)) begin
            press_ms_d = press_ms_q + 1'b1;
        end
    end

    // Saturation at LONG_T keeps long_evt to one pulse and blocks a short on release.
    assign long_evt  = !btn_n && int_1ms_en && (press_ms_q == LONG_M1_T);
    assign short_evt = btn_n && !btn_n_prev_q &&
                       (press_ms_q >= SHORT_T) && (press_ms_q < LONG_T);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_ms_q   <= '0;
            btn_n_prev_q <= 1'b1;
        end else begin
            press_ms_q   <= press_ms_d;
            btn_n_prev_q <= btn_n_prev_d;
        end
    end

endmodule

// File: rtl/pwr_btn_ctrl.sv
// rtl/pwr_btn_ctrl.sv - power-button driven rail sequencer with graceful and forced shutdown
module pwr_btn_ctrl
    import pwr_btn_pkg::*;
#(
    parameter int SHORT_MIN_MS  = 50,
    parameter int LONG_PRESS_MS = 4000,
    parameter int PGOOD_TMO_MS  = 500,
    parameter int SHDN_TMO_MS   = 10000,
    parameter int TW            = TW_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       int_1ms_en,
    input  logic       btn_n,
    input  logic       pg_all,
    input  logic       soc_off_ack,
    output logic       pwr_en,
    output logic       soc_shutdown_req,
    output logic       fault,
    output logic [2:0] state_out
);

    localparam logic [TW-1:0] PGOOD_T = TW'(PGOOD_TMO_MS);
    localparam logic [TW-1:0] SHDN_T  = TW'(SHDN_TMO_MS);

    logic          short_evt, long_evt;
    logic [1:0]    pg_sync_q, pg_sync_d;
    logic [1:0]    ack_sync_q, ack_sync_d;
    logic          pg_s, ack_s;
    state_e        state_q, next_state;
    logic [TW-1:0] tmr_q, tmr_d;
    outs_t         outs_q, outs_d;

    pwr_btn_press_cls #(
        .TW            (TW),
        .SHORT_MIN_MS  (SHORT_MIN_MS),
        .LONG_PRESS_MS (LONG_PRESS_MS)
    ) u_press_cls (
        .clock      (clock),
        .reset      (reset),
        .int_1ms_en (int_1ms_en),
        .btn_n      (btn_n),
        .short_evt  (short_evt),
        .long_evt   (long_evt)
    );

    assign pg_sync_d  = {pg_sync_q[0], pg_all};
    assign ack_sync_d = {ack_sync_q[0], soc_off_ack};
    assign pg_s       = pg_sync_q[1];
    assign ack_s      = ack_sync_q[1];

    // Power-good loss is tested first wherever the rail is up.
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_OFF: begin
                if (short_evt) next_state = ST_PWR_UP;
            end
            ST_PWR_UP: begin
                if (pg_s)                  next_state = ST_ON;
                else if (long_evt)         next_state = ST_PWR_DOWN;
                else if (tmr_q == PGOOD_T) next_state = ST_FAULT;
            end
            ST_ON: begin
                if (!pg_s)          next_state = ST_FAULT;
                else if (long_evt)  next_state = ST_PWR_DOWN;
                else if (short_evt) next_state = ST_SHDN_REQ;
            end
            ST_SHDN_REQ: begin
                if (!pg_s)                                  next_state = ST_FAULT;
                else if (ack_s || long_evt || tmr_q == SHDN_T) next_state = ST_PWR_DOWN;
            end
            ST_PWR_DOWN: begin
                if (!pg_s) next_state = ST_OFF;
            end
            ST_FAULT: begin
                if (short_evt && !pg_s) next_state = ST_OFF;
            end
            default: next_state = ST_OFF;
        endcase
    end

    always_comb begin
        tmr_d = tmr_q;
        if (next_state != state_q) begin
            tmr_d = '0;
        end else if (int_1ms_en && (tmr_q != '1)) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    assign outs_d = decode_outs(next_state);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OFF;
            tmr_q      <= '0;
            outs_q     <= '0;
            pg_sync_q  <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= next_state;
            tmr_q      <= tmr_d;
            outs_q     <= outs_d;
            pg_sync_q  <= pg_sync_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign pwr_en           = outs_q.pwr_en;
    assign soc_shutdown_req = outs_q.shdn_req;
    assign fault            = outs_q.fault;
    assign state_out        = state_q;

endmodule

// File: tb/tb_pwr_btn_ctrl.sv
// tb/tb_pwr_btn_ctrl.sv - self-checking bench for pwr_btn_ctrl against a behavioural model
module tb_pwr_btn_ctrl;

    localparam int SHORT = 5;
    localparam int LONG  = 40;
    localparam int PGT   = 20;
    localparam int SDT   = 100;
    localparam int TMAX  = 65535;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       int_1ms_en = 1'b0;
    logic       btn_n = 1'b1;
    logic       pg_all = 1'b0;
    logic       soc_off_ack = 1'b0;
    logic       pwr_en, soc_shutdown_req, fault;
    logic [2:0] state_out;

    always #5 clock = ~clock;

    pwr_btn_ctrl #(
        .SHORT_MIN_MS  (SHORT),
        .LONG_PRESS_MS (LONG),
        .PGOOD_TMO_MS  (PGT),
        .SHDN_TMO_MS   (SDT),
        .TW            (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .int_1ms_en       (int_1ms_en),
        .btn_n            (btn_n),
        .pg_all           (pg_all),
        .soc_off_ack      (soc_off_ack),
        .pwr_en           (pwr_en),
        .soc_shutdown_req (soc_shutdown_req),
        .fault            (fault),
        .state_out        (state_out)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model: held time in ms, a 2-deep history for each async input,
    // and the state machine written directly from the rule list.
    int m_st = 0, m_tmr = 0, m_hold = 0, m_nst = 0;
    bit m_prev_btn = 1'b1;
    bit pg_h1 = 0, pg_h2 = 0, ack_h1 = 0, ack_h2 = 0;
    bit m_sev, m_lev;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_tmr = 0; m_hold = 0; m_prev_btn = 1'b1;
            pg_h1 = 0; pg_h2 = 0; ack_h1 = 0; ack_h2 = 0;
        end else begin
            m_sev = btn_n && !m_prev_btn && (m_hold >= SHORT) && (m_hold < LONG);
            m_lev = !btn_n && int_1ms_en && (m_hold + 1 == LONG);
            m_nst = m_st;
            case (m_st)
                0: if (m_sev) m_nst = 1;
                1: if (pg_h2) m_nst = 2; else if (m_lev) m_nst = 4; else if (m_tmr == PGT) m_nst = 5;
                2: if (!pg_h2) m_nst = 5; else if (m_lev) m_nst = 4; else if (m_sev) m_nst = 3;
                3: if (!pg_h2) m_nst = 5; else if (ack_h2 || m_lev || m_tmr == SDT) m_nst = 4;
                4: if (!pg_h2) m_nst = 0;
                5: if (m_sev && !pg_h2) m_nst = 0;
                default: m_nst = 0;
            endcase
            if (m_nst != m_st) m_tmr = 0;
            else if (int_1ms_en && m_tmr < TMAX) m_tmr = m_tmr + 1;
            m_st = m_nst;
            if (btn_n) m_hold = 0;
            else if (int_1ms_en && m_hold < LONG) m_hold = m_hold + 1;
            m_prev_btn = btn_n;
            pg_h2 = pg_h1; pg_h1 = pg_all;
            ack_h2 = ack_h1; ack_h1 = soc_off_ack;
        end
    end

    int cyc = 0;
    bit auto_rail = 1'b0;

    task automatic rail();
        if (pwr_en && !pg_all && $urandom_range(0, 29) == 0) pg_all = 1'b1;
        else if (!pwr_en && pg_all && $urandom_range(0, 19) == 0) pg_all = 1'b0;
        else if (pwr_en && pg_all && $urandom_range(0, 19999) == 0) pg_all = 1'b0;
        if (!soc_shutdown_req) soc_off_ack = 1'b0;
        else if ($urandom_range(0, 299) == 0) soc_off_ack = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
        chk("pwr_en", int'(pwr_en), int'(m_st >= 1 && m_st <= 3));
        chk("shdn_req", int'(soc_shutdown_req), int'(m_st == 3));
        chk("fault", int'(fault), int'(m_st == 5));
        chk("state", int'(state_out), m_st);
        cyc++;
        int_1ms_en = (cyc % 10 == 0);
        if (auto_rail) rail();
    endtask

    task automatic wait_ms(input int n);
        repeat (n * 10) step();
    endtask

    task automatic press(input int ms);
        btn_n = 1'b0;
        wait_ms(ms);
        btn_n = 1'b1;
        step();
    endtask

    task automatic goto_on();
        press(10);
        pg_all = 1'b1;
        wait_ms(2);
        chk("goto_on", int'(state_out), 2);
    endtask

    int n;
    int bound;

    initial begin
        repeat (3) step();
        chk("rst_state", int'(state_out), 0);
        chk("rst_pwr_en", int'(pwr_en), 0);
        chk("rst_fault", int'(fault), 0);
        reset = 1'b1;
        wait_ms(2);

        // power on
        press(10);
        chk("pwrup_state", int'(state_out), 1);
        chk("pwrup_en", int'(pwr_en), 1);
        wait_ms(8);
        pg_all = 1'b1;
        wait_ms(1);
        chk("on_state", int'(state_out), 2);
        chk("on_fault", int'(fault), 0);
        pg_all = 1'b0;
        wait_ms(1);
        chk("pgloss_fault", int'(state_out), 5);
        press(10);
        chk("fault_clear", int'(state_out), 0);

        // glitch, then power-good timeout, then clear
        press(3);
        wait_ms(2);
        chk("glitch_off", int'(state_out), 0);
        chk("glitch_en", int'(pwr_en), 0);
        press(10);
        chk("pgt_pwrup", int'(state_out), 1);
        wait_ms(25);
        chk("pgt_state", int'(state_out), 5);
        chk("pgt_fault", int'(fault), 1);
        chk("pgt_en", int'(pwr_en), 0);
        press(10);
        chk("pgt_clr_state", int'(state_out), 0);
        chk("pgt_clr_fault", int'(fault), 0);

        // graceful off
        goto_on();
        press(10);
        chk("gr_state", int'(state_out), 3);
        chk("gr_req", int'(soc_shutdown_req), 1);
        soc_off_ack = 1'b1;
        repeat (4) step();
        chk("gr_down", int'(state_out), 4);
        chk("gr_down_en", int'(pwr_en), 0);
        soc_off_ack = 1'b0;
        pg_all = 1'b0;
        repeat (4) step();
        chk("gr_off", int'(state_out), 0);

        // shutdown timeout
        goto_on();
        press(10);
        chk("sdt_req", int'(state_out), 3);
        n = int'(int_1ms_en);
        bound = 0;
        while (bound < 3000) begin
            step();
            bound++;
            if (state_out != 3'd3) break;
            n += int'(int_1ms_en);
        end
        chk("sdt_ticks", n, 100);
        chk("sdt_down", int'(state_out), 4);
        pg_all = 1'b0;
        repeat (4) step();
        chk("sdt_off", int'(state_out), 0);

        // forced off by long press
        goto_on();
        btn_n = 1'b0;
        n = int'(int_1ms_en);
        bound = 0;
        while (bound < 1000) begin
            step();
            bound++;
            if (state_out != 3'd2) break;
            n += int'(int_1ms_en);
        end
        chk("long_ticks", n, 40);
        chk("long_down", int'(state_out), 4);
        pg_all = 1'b0;
        repeat (4) step();
        chk("long_off", int'(state_out), 0);
        wait_ms(20);
        btn_n = 1'b1;
        wait_ms(2);
        chk("long_rel_state", int'(state_out), 0);
        chk("long_rel_en", int'(pwr_en), 0);

        // pg loss coincident with short_evt
        goto_on();
        btn_n = 1'b0;
        wait_ms(10);
        pg_all = 1'b0;
        step();
        step();
        btn_n = 1'b1;
        step();
        chk("prio_fault", int'(state_out), 5);
        press(10);
        chk("prio_clear", int'(state_out), 0);

        // asynchronous reset while on
        goto_on();
        chk("prerst_en", int'(pwr_en), 1);
        #3 reset = 1'b0;
        #1 chk("async_rst_en", int'(pwr_en), 0);
        chk("async_rst_state", int'(state_out), 0);
        repeat (3) step();
        reset = 1'b1;
        pg_all = 1'b0;
        step();
        chk("post_rst_state", int'(state_out), 0);

        // randomized presses against the model
        auto_rail = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_ms($urandom_range(1, 20));
            press($urandom_range(1, 60));
        end
        auto_rail = 1'b0;
        wait_ms(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwr_btn_ctrl.md
Name: pwr_btn_ctrl

Overview:
- Front-panel power controller in the board CPLD. Consumes the debounced power-button level and the shared 1 ms tick.
- Classifies each press as short or long, then sequences the main rail enable against the rail power-good.
- Short press while on requests a graceful SoC shutdown; long press forces power off.
- Sits between the button debounce logic and the rail sequencer / SoC shutdown GPIO.

Parameters:
- SHORT_MIN_MS, 50: minimum hold (ms) for a press to count as short; shorter presses are ignored.
- LONG_PRESS_MS, 4000: hold time (ms) at which a long press fires.
- PGOOD_TMO_MS, 500: maximum wait (ms) for pg_all after pwr_en rises.
- SHDN_TMO_MS, 10000: maximum wait (ms) for soc_off_ack after a shutdown request.
- TW, 16: width of the ms counters. All ms parameters must be < 2^TW.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- int_1ms_en, in, 1: one-clock strobe every 1 ms.
- btn_n, in, 1: debounced button, low = pressed; synchronous to clock.
- pg_all, in, 1: rail power-good; asynchronous, 2-flop synchronised internally.
- soc_off_ack, in, 1: SoC shutdown acknowledge, level high; asynchronous, 2-flop synchronised internally.
- pwr_en, out, 1: main rail enable.
- soc_shutdown_req, out, 1: graceful shutdown request to SoC.
- fault, out, 1: power fault indicator.
- state_out, out, 3: current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active low; clock is clock.
- Reset values: pwr_en 0, soc_shutdown_req 0, fault 0, state OFF, all counters 0, synchroniser flops 0.
- Press classifier:
  - press_ms clears while btn_n=1 and increments on int_1ms_en while btn_n=0, saturating at LONG_PRESS_MS.
  - long_evt: 1-clock pulse on the tick where press_ms reaches LONG_PRESS_MS; at most once per press.
  - short_evt: 1-clock pulse on the 0->1 edge of btn_n if SHORT_MIN_MS <= press_ms < LONG_PRESS_MS.
  - Release after a long press produces no short_evt.
- State timer tmr clears on every state change, increments on int_1ms_en, and saturates at all-ones.
- Outputs are registered from next_state, so they change on the same edge as the state register. pg_all and soc_off_ack carry 2 clocks of synchroniser latency.
- States and encodings: OFF=0, PWR_UP=1, ON=2, SHDN_REQ=3, PWR_DOWN=4, FAULT=5. Codes 6 and 7 return to OFF with all outputs deasserted.
- OFF (all outputs 0):
  - short_evt -> PWR_UP.
  - long_evt ignored.
- PWR_UP (pwr_en=1), checked in priority order:
  - pg_all=1 -> ON.
  - else long_evt -> PWR_DOWN.
  - else tmr==PGOOD_TMO_MS -> FAULT.
- ON (pwr_en=1), checked in priority order:
  - pg_all=0 -> FAULT.
  - else long_evt -> PWR_DOWN.
  - else short_evt -> SHDN_REQ.
- SHDN_REQ (pwr_en=1, soc_shutdown_req=1), checked in priority order:
  - pg_all=0 -> FAULT.
  - else soc_off_ack=1, long_evt, or tmr==SHDN_TMO_MS -> PWR_DOWN.
  - short_evt ignored.
- PWR_DOWN (all outputs 0):
  - pg_all=0 -> OFF.
  - Button events ignored.
- FAULT (fault=1, pwr_en=0):
  - short_evt with pg_all=0 -> OFF, which clears fault.
  - Otherwise hold.
- Simultaneous events resolve by the priority orders above. A power-good loss always beats button events.
- A press in progress across a state change keeps counting; its event is evaluated in whatever state is current when it fires.
- Reset mid-operation drops pwr_en in the same cycle (asynchronous) and discards any partial press.

Decomposition:
- Package pwr_btn_pkg holds the 3-bit state localparams and the TW default.
- Sub-module pwr_btn_press_cls contains the press_ms counter and short/long event generation. Its ports: clock, reset, int_1ms_en, btn_n, short_evt, long_evt.
- The top level holds the synchronisers, the state timer and the FSM.

Test Plan:
All scenarios use SHORT_MIN_MS=5, LONG_PRESS_MS=40, PGOOD_TMO_MS=20, SHDN_TMO_MS=100, with a 1 ms tick every 10 clocks.
- Power on: 10 ms press with pg_all rising 8 ms later -> pwr_en=1 one clock after release; state PWR_UP then ON; fault=0.
- Glitch and PG timeout: 3 ms press -> stays OFF, pwr_en=0. Then a 10 ms press with pg_all held 0 -> FAULT at tmr=20, pwr_en=0, fault=1. Then a 10 ms press -> OFF, fault=0.
- Graceful off: in ON, 10 ms press -> soc_shutdown_req=1. soc_off_ack=1 -> PWR_DOWN, pwr_en=0. pg_all=0 -> OFF.
- Shutdown timeout: in SHDN_REQ with no ack -> PWR_DOWN after exactly 100 ticks.
- Forced off: in ON, hold 60 ms -> PWR_DOWN on the 40th tick; release produces no short_evt; system ends in OFF, not PWR_UP.
- Priority and reset: in ON, pg_all falls on the same cycle as short_evt -> FAULT. Reset asserted in ON -> pwr_en=0 immediately; after release, state=0.
